// File: rtl/out_port_serializer_if.sv
// Bundle between one crossbar output port and the serial beat stream leaving the serializer.
// The master side feeds words and grants beats; the slave side is the serializer.
interface out_port_serializer_if #(
   parameter int unsigned DATA_WIDTH = 480,
   parameter int unsigned CTRL_WIDTH = 32,
   parameter int unsigned OUT_WIDTH  = 96
);
   logic                  in_wr;
   logic [CTRL_WIDTH-1:0] in_ctl;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [OUT_WIDTH-1:0]  out_data;
   logic [CTRL_WIDTH-1:0] out_ctl;
   logic                  out_sop;
   logic                  out_eop;

   modport master (
      output in_wr, in_ctl, in_data, out_ready,
      input  out_valid, out_data, out_ctl, out_sop, out_eop
   );

   modport slave (
      input  in_wr, in_ctl, in_data, out_ready,
      output out_valid, out_data, out_ctl, out_sop, out_eop
   );
endinterface

// File: rtl/out_port_serializer.sv
// Buffers wide crossbar words in a small FIFO and streams each one out as NUM_BEATS
// narrow beats, LSB slice first, with sop/eop markers and drop/packet statistics.
module out_port_serializer #(
   parameter int unsigned DATA_WIDTH = 480,
   parameter int unsigned CTRL_WIDTH = 32,
   parameter int unsigned OUT_WIDTH  = 96,
   parameter int unsigned DEPTH_BITS = 2,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   out_port_serializer_if.slave  bus,
   output logic [DEPTH_BITS:0]   level,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic [CNT_WIDTH-1:0]  pkt_cnt
);
   localparam int unsigned NumBeats = DATA_WIDTH / OUT_WIDTH;
   localparam int unsigned Depth    = 2 ** DEPTH_BITS;
   localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
   localparam int unsigned EntryW   = CTRL_WIDTH + DATA_WIDTH;

   localparam logic [BeatW-1:0]    LastBeat  = BeatW'(NumBeats - 1);
   localparam logic [DEPTH_BITS:0] FullLevel = (DEPTH_BITS + 1)'(Depth);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]                          state_q, state_d;
   logic [BeatW-1:0]                    beat_q, beat_d;
   logic [NumBeats-1:0][OUT_WIDTH-1:0]  hold_data_q;
   logic [CTRL_WIDTH-1:0]               hold_ctl_q;
   logic [EntryW-1:0]                   mem_q [Depth];
   logic [DEPTH_BITS-1:0]               wr_ptr_q, rd_ptr_q;
   logic [DEPTH_BITS:0]                 level_q, level_d;
   logic [CNT_WIDTH-1:0]                drop_q, pkt_q;

   logic xfer, last_xfer, pop, push, drop;

   assign xfer      = (state_q == SEND) && bus.out_ready;
   assign last_xfer = xfer && (beat_q == LastBeat);
   // Head is popped either to start from idle or right on the eop beat, so words never bubble.
   assign pop       = (level_q != '0) && ((state_q == IDLE) || last_xfer);
   assign push      = bus.in_wr && ((level_q != FullLevel) || pop);
   assign drop      = bus.in_wr && !push;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d = SEND;
               beat_d  = '0;
            end
         end
         SEND: begin
            if (last_xfer) begin
               if (pop) beat_d = '0;
               else     state_d = IDLE;
            end else if (xfer) begin
               beat_d = beat_q + BeatW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      level_d = level_q;
      if (push && !pop)      level_d = level_q + (DEPTH_BITS + 1)'(1);
      else if (pop && !push) level_d = level_q - (DEPTH_BITS + 1)'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         hold_data_q <= '0;
         hold_ctl_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         drop_q      <= '0;
         pkt_q       <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         level_q <= level_d;
         if (pop) begin
            {hold_ctl_q, hold_data_q} <= mem_q[rd_ptr_q];
            rd_ptr_q                  <= rd_ptr_q + DEPTH_BITS'(1);
         end
         if (push) wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
         if (drop && (drop_q != '1)) drop_q <= drop_q + CNT_WIDTH'(1);
         if (last_xfer && (pkt_q != '1)) pkt_q <= pkt_q + CNT_WIDTH'(1);
      end
   end

   // Storage needs no reset: level and pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus.in_ctl, bus.in_data};
   end

   // beat_q is left on the last slice when idle, so out_data keeps its last value.
   assign bus.out_valid = (state_q == SEND);
   assign bus.out_sop   = (state_q == SEND) && (beat_q == '0);
   assign bus.out_eop   = (state_q == SEND) && (beat_q == LastBeat);
   assign bus.out_data  = hold_data_q[beat_q];
   assign bus.out_ctl   = hold_ctl_q;

   assign level    = level_q;
   assign drop_cnt = drop_q;
   assign pkt_cnt  = pkt_q;
endmodule

// File: tb/tb_out_port_serializer.sv
// Directed bench for out_port_serializer: word i carries beat b = i*16+b+1 so every slice
// identifies its word and position; inputs change and outputs are sampled on the falling edge.
module tb_out_port_serializer;
   localparam int DW = 480;
   localparam int CW = 32;
   localparam int OW = 96;
   localparam int DB = 2;
   localparam int CNTW = 32;
   localparam int NB = 5;

   typedef logic [3+CW+OW-1:0] tup_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [DB:0]     level;
   logic [CNTW-1:0] drop_cnt;
   logic [CNTW-1:0] pkt_cnt;
   int              checks = 0;
   int              errors = 0;

   always #5 clk = ~clk;

   out_port_serializer_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .OUT_WIDTH(OW)) bus ();

   out_port_serializer #(
      .DATA_WIDTH(DW),
      .CTRL_WIDTH(CW),
      .OUT_WIDTH (OW),
      .DEPTH_BITS(DB),
      .CNT_WIDTH (CNTW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .level   (level),
      .drop_cnt(drop_cnt),
      .pkt_cnt (pkt_cnt)
   );

   function automatic logic [DW-1:0] mk_word(int id);
      logic [DW-1:0] w;
      for (int b = 0; b < NB; b++) w[b*OW +: OW] = OW'(id * 16 + b + 1);
      return w;
   endfunction

   // {valid, sop, eop, ctl, data} expected while beat b of word id is presented
   function automatic tup_t exp_tup(int b, int id, logic [CW-1:0] ctl);
      return {1'b1, (b == 0), (b == NB - 1), ctl, OW'(id * 16 + b + 1)};
   endfunction

   function automatic tup_t obs();
      return {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_ctl, bus.out_data};
   endfunction

   task automatic drive_word(int id, logic [CW-1:0] ctl);
      bus.in_wr   = 1'b1;
      bus.in_ctl  = ctl;
      bus.in_data = mk_word(id);
   endtask

   task automatic test_reset();
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      drive_word(99, 32'h99);
      repeat (2) @(negedge clk);
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, want 0", obs());
      end
      checks++;
      if ({level, drop_cnt, pkt_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_counters: got level=%0d drop=%0d pkt=%0d, want 0/0/0",
                  level, drop_cnt, pkt_cnt);
      end
      bus.in_wr = 1'b0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.out_valid, level, drop_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_release: got valid=%b level=%0d drop=%0d, want 0/0/0",
                  bus.out_valid, level, drop_cnt);
      end
   endtask

   task automatic test_single();
      drive_word(0, 32'hA5);
      @(negedge clk);
      bus.in_wr = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_n1_valid: got %b, want 0", bus.out_valid);
      end
      for (int b = 0; b < NB; b++) begin
         @(negedge clk);
         checks++;
         if (obs() !== exp_tup(b, 0, 32'hA5)) begin
            errors++;
            $display("FAIL single_beat%0d: got %h, want %h", b, obs(), exp_tup(b, 0, 32'hA5));
         end
      end
      @(negedge clk);
      checks++;
      if (obs() !== {3'b000, 32'hA5, 96'h5}) begin
         errors++;
         $display("FAIL single_idle_hold: got %h, want %h", obs(), {3'b000, 32'hA5, 96'h5});
      end
      checks++;
      if ({pkt_cnt, level} !== {32'd1, 3'd0}) begin
         errors++;
         $display("FAIL single_counts: got pkt=%0d level=%0d, want 1/0", pkt_cnt, level);
      end
   endtask

   task automatic test_backpressure();
      int rdy[7] = '{1, 0, 0, 1, 1, 1, 1};
      int eb[7]  = '{0, 1, 1, 1, 2, 3, 4};
      drive_word(1, 32'h1);
      @(negedge clk);
      bus.in_wr = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus.out_ready = rdy[i][0];
         checks++;
         if (obs() !== exp_tup(eb[i], 1, 32'h1)) begin
            errors++;
            $display("FAIL backpressure_cyc%0d: got %h, want %h", i, obs(), exp_tup(eb[i], 1, 32'h1));
         end
      end
      @(negedge clk);
      checks++;
      if ({bus.out_valid, pkt_cnt} !== {1'b0, 32'd2}) begin
         errors++;
         $display("FAIL backpressure_end: got valid=%b pkt=%0d, want 0/2", bus.out_valid, pkt_cnt);
      end
   endtask

   // Word 2 is stalled in SEND, four more fill the FIFO, two drop; then an in_wr lands on the
   // stalled word's eop transfer while full and must be taken in.
   task automatic test_overflow();
      int ids[6] = '{2, 3, 4, 5, 6, 9};
      bus.out_ready = 1'b0;
      drive_word(2, 32'h2);
      @(negedge clk);
      bus.in_wr = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         drive_word(3 + k, CW'(3 + k));
         @(negedge clk);
      end
      bus.in_wr = 1'b0;
      checks++;
      if ({level, drop_cnt} !== {3'd4, 32'd2}) begin
         errors++;
         $display("FAIL overflow_full: got level=%0d drop=%0d, want 4/2", level, drop_cnt);
      end
      bus.out_ready = 1'b1;
      for (int w = 0; w < 6; w++) begin
         for (int b = 0; b < NB; b++) begin
            checks++;
            if (obs() !== exp_tup(b, ids[w], CW'(ids[w]))) begin
               errors++;
               $display("FAIL overflow_w%0d_b%0d: got %h, want %h", w, b, obs(),
                        exp_tup(b, ids[w], CW'(ids[w])));
            end
            if (w == 0 && b == NB - 1) drive_word(9, 32'h9);
            else bus.in_wr = 1'b0;
            if (w == 1 && b == 0) begin
               checks++;
               if ({level, drop_cnt} !== {3'd4, 32'd2}) begin
                  errors++;
                  $display("FAIL full_pop_write: got level=%0d drop=%0d, want 4/2", level, drop_cnt);
               end
            end
            @(negedge clk);
         end
      end
      checks++;
      if ({bus.out_valid, level, pkt_cnt} !== {1'b0, 3'd0, 32'd8}) begin
         errors++;
         $display("FAIL overflow_end: got valid=%b level=%0d pkt=%0d, want 0/0/8",
                  bus.out_valid, level, pkt_cnt);
      end
   endtask

   task automatic test_back_to_back();
      drive_word(10, 32'hA);
      @(negedge clk);
      drive_word(11, 32'hB);
      @(negedge clk);
      for (int i = 0; i < 3 * NB; i++) begin
         if (i == 0) drive_word(12, 32'hC);
         else bus.in_wr = 1'b0;
         checks++;
         if (obs() !== exp_tup(i % NB, 10 + i / NB, CW'(10 + i / NB))) begin
            errors++;
            $display("FAIL b2b_cyc%0d: got %h, want %h", i, obs(),
                     exp_tup(i % NB, 10 + i / NB, CW'(10 + i / NB)));
         end
         @(negedge clk);
      end
      checks++;
      if ({bus.out_valid, pkt_cnt} !== {1'b0, 32'd11}) begin
         errors++;
         $display("FAIL b2b_end: got valid=%b pkt=%0d, want 0/11", bus.out_valid, pkt_cnt);
      end
   endtask

   task automatic test_reset_mid_word();
      drive_word(13, 32'hD);
      @(negedge clk);
      drive_word(14, 32'hE);
      @(negedge clk);
      bus.in_wr = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs() !== exp_tup(2, 13, 32'hD)) begin
         errors++;
         $display("FAIL rstmid_beat2: got %h, want %h", obs(), exp_tup(2, 13, 32'hD));
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (obs() !== '0 || {level, drop_cnt, pkt_cnt} !== '0) begin
         errors++;
         $display("FAIL rstmid_async: got out=%h level=%0d drop=%0d pkt=%0d, want all 0",
                  obs(), level, drop_cnt, pkt_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.out_valid, level} !== '0) begin
            errors++;
            $display("FAIL rstmid_after%0d: got valid=%b level=%0d, want 0/0",
                     i, bus.out_valid, level);
         end
      end
   endtask

   initial begin
      bus.in_wr     = 1'b0;
      bus.in_ctl    = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_back_to_back();
      test_reset_mid_word();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
